gbus_wr_sched: RTL and testbench
================================

Name: gbus_wr_sched

Overview:
- Upstream feeder for one head row of the core array: turns a command plus a 64-bit word stream into that head's global-bus write traffic (address, per-core write enable, write data).
- One instance per head; its outputs drive that head's in_GBUS_ADDR, gbus_wen and gbus_wdata slices.
- Two write modes:
  - broadcast: each word is written to every selected core.
  - scatter: successive words go to successive selected cores in round-robin order.

Parameters:
- VNUM, 8, cores per head (width of write-enable vector)
- GBUS_DATA, 64, bus data width
- GBUS_ADDR, 12, bus address width
- LEN_BIT, 12, width of the word-count field

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  1  0 = broadcast, 1 = scatter
- cmd_core_mask  in  VNUM  cores selected as targets
- cmd_base_addr  in  GBUS_ADDR  first write address
- cmd_len  in  LEN_BIT  number of input words to consume
- in_valid  in  1  data word offered
- in_ready  out  1  high only in RUN
- in_data  in  GBUS_DATA  data word
- gbus_addr  out  GBUS_ADDR  registered write address
- gbus_wen  out  VNUM  registered per-core write enable
- gbus_wdata  out  GBUS_DATA  registered write data
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- cmd_err  out  1  one-cycle pulse, coincident with done, when a command is rejected

Behaviour:
- Reset (async, rstn low): every output register cleared: gbus_addr=0, gbus_wen=0, gbus_wdata=0, done=0, cmd_err=0; state=IDLE. A reset mid-command abandons the command with no done pulse. After release, cmd_ready=1.
- FSM has three states: IDLE, RUN, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch mode, mask, base address and length; set word counter to 0.
  - If cmd_len==0 or cmd_core_mask==0, go to FIN. cmd_err=1 only for the zero-mask case.
  - Otherwise go to RUN.
- RUN:
  - in_ready=1. A word is accepted when in_valid && in_ready.
  - The accepted word appears on gbus_wdata/gbus_addr/gbus_wen in the next cycle (latency 1). gbus_wen is 0 in every cycle after which no word was accepted.
  - Broadcast: gbus_wen = mask. The address advances by 1 after every accepted word.
  - Scatter:
    - gbus_wen is one-hot at the current core pointer.
    - The pointer starts at the lowest set bit of the mask.
    - After each word the pointer moves to the next higher set bit.
    - Moving past the highest set bit wraps to the lowest set bit and advances the address by 1.
    - A single-bit mask therefore advances the address on every word.
  - Address arithmetic is modulo 2^GBUS_ADDR (0xFFF+1 -> 0x000).
  - When the word completing cmd_len is accepted, go to FIN; in_ready drops in that next cycle.
- FIN: done=1 for exactly one cycle, then IDLE. The final write and done are visible in the same cycle.
- No ready/backpressure from the core array: cores always accept gbus writes.
- in_valid while not in RUN is ignored; no word is consumed.
- cmd_valid while busy is ignored (cmd_ready=0). A new command is accepted at the earliest one cycle after done.
- in_valid gaps in RUN stall progress without error; counter, pointer and address hold.
- Length counts input words. In broadcast mode each word produces popcount(mask) core writes in one cycle.

Test Plan:
- Reset then idle: rstn low 2 cycles, release -> all outputs 0, cmd_ready=1, busy=0; in_valid=1 with data 0xDEADBEEFDEADBEEF -> in_ready=0, gbus_wen stays 0.
- Broadcast: mode=0, mask=0x0F, base=0x010, len=3, data D0..D2 back-to-back -> three cycles of gbus_wen=0x0F at addr 0x010,0x011,0x012 carrying D0..D2; done pulse in the cycle of the last write; cmd_ready back to 1 one cycle later.
- Scatter: mode=1, mask=0xA5, base=0x100, len=6 -> wen sequence 0x01,0x04,0x20,0x80,0x01,0x04 with addr 0x100 x4 then 0x101 x2; done after the 6th write.
- Stall and wrap: mode=0, mask=0x01, base=0xFFE, len=4, in_valid toggled 1,0,1,1,0,1 -> writes at 0xFFE,0xFFF,0x000,0x001 only in the cycle after each accepted word; no write in the stalled cycles.
- Degenerate commands: len=0 with mask=0xFF -> no writes, done=1, cmd_err=0; mask=0 with len=5 -> no writes, done=1 and cmd_err=1, in_ready never asserted.
- Reset mid-command: scatter with len=8, assert rstn low after 3 accepted words -> outputs clear asynchronously; no done pulse; the next command runs correctly from its own base address.

Source files
------------

// File: rtl/gbus_wr_sched.sv
// Global-bus write scheduler for one head row: turns a command plus a word stream into
// registered per-core gbus writes, in broadcast or round-robin scatter mode.
module gbus_wr_sched #(
    parameter int unsigned VNUM      = 8,
    parameter int unsigned GBUS_DATA = 64,
    parameter int unsigned GBUS_ADDR = 12,
    parameter int unsigned LEN_BIT   = 12
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_mode_i,
    input  logic [VNUM-1:0]      cmd_core_mask_i,
    input  logic [GBUS_ADDR-1:0] cmd_base_addr_i,
    input  logic [LEN_BIT-1:0]   cmd_len_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [GBUS_DATA-1:0] in_data_i,
    output logic [GBUS_ADDR-1:0] gbus_addr_o,
    output logic [VNUM-1:0]      gbus_wen_o,
    output logic [GBUS_DATA-1:0] gbus_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 cmd_err_o
);

    localparam int unsigned PtrW = (VNUM > 1) ? $clog2(VNUM) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e               state_q;
    logic                 mode_q;
    logic [VNUM-1:0]      mask_q;
    logic [GBUS_ADDR-1:0] addr_q;
    logic [LEN_BIT-1:0]   len_q;
    logic [LEN_BIT-1:0]   cnt_q;
    logic [PtrW-1:0]      ptr_q;

    logic [GBUS_ADDR-1:0] gbus_addr_q;
    logic [VNUM-1:0]      gbus_wen_q;
    logic [GBUS_DATA-1:0] gbus_wdata_q;
    logic                 done_q;
    logic                 cmd_err_q;

    logic [PtrW-1:0]      ptr_hi;
    logic                 ptr_hi_vld;
    logic [PtrW-1:0]      ptr_lo;
    logic [PtrW-1:0]      ptr_start;
    logic [PtrW-1:0]      ptr_d;
    logic [GBUS_ADDR-1:0] addr_d;
    logic [LEN_BIT-1:0]   cnt_d;
    logic                 last_word;
    logic [VNUM-1:0]      wen_word;
    logic                 accept;

    function automatic logic [PtrW-1:0] lowest_set(input logic [VNUM-1:0] m);
        lowest_set = '0;
        for (int i = int'(VNUM) - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = PtrW'(i);
        end
    endfunction

    // Nearest set mask bit strictly above the current pointer, if any.
    always_comb begin
        ptr_hi     = '0;
        ptr_hi_vld = 1'b0;
        for (int i = int'(VNUM) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ptr_q))) begin
                ptr_hi     = PtrW'(i);
                ptr_hi_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_lo    = lowest_set(mask_q);
        ptr_start = lowest_set(cmd_core_mask_i);
        accept    = (state_q == StRun) && in_valid_i;
        cnt_d     = cnt_q + LEN_BIT'(1);
        last_word = (cnt_d == len_q);
        wen_word  = mode_q ? (VNUM'(1) << ptr_q) : mask_q;
        ptr_d     = ptr_hi_vld ? ptr_hi : ptr_lo;
        // Scatter only moves to the next address row when the pointer wraps.
        addr_d    = addr_q + GBUS_ADDR'(!mode_q || !ptr_hi_vld);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            mask_q       <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            gbus_addr_q  <= '0;
            gbus_wen_q   <= '0;
            gbus_wdata_q <= '0;
            done_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    gbus_wen_q <= '0;
                    done_q     <= 1'b0;
                    cmd_err_q  <= 1'b0;
                    if (cmd_valid_i) begin
                        mode_q <= cmd_mode_i;
                        mask_q <= cmd_core_mask_i;
                        addr_q <= cmd_base_addr_i;
                        len_q  <= cmd_len_i;
                        cnt_q  <= '0;
                        ptr_q  <= ptr_start;
                        if (cmd_len_i == '0 || cmd_core_mask_i == '0) begin
                            state_q   <= StFin;
                            done_q    <= 1'b1;
                            cmd_err_q <= (cmd_core_mask_i == '0);
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        gbus_wen_q   <= wen_word;
                        gbus_addr_q  <= addr_q;
                        gbus_wdata_q <= in_data_i;
                        cnt_q        <= cnt_d;
                        addr_q       <= addr_d;
                        if (mode_q) ptr_q <= ptr_d;
                        if (last_word) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        gbus_wen_q <= '0;
                    end
                end
                StFin: begin
                    gbus_wen_q <= '0;
                    done_q     <= 1'b0;
                    cmd_err_q  <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    gbus_wen_q <= '0;
                    done_q     <= 1'b0;
                    cmd_err_q  <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign in_ready_o   = (state_q == StRun);
    assign busy_o       = (state_q != StIdle);
    assign gbus_addr_o  = gbus_addr_q;
    assign gbus_wen_o   = gbus_wen_q;
    assign gbus_wdata_o = gbus_wdata_q;
    assign done_o       = done_q;
    assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_gbus_wr_sched.sv
// Randomized self-checking bench for gbus_wr_sched against a word-index reference model.
module tb_gbus_wr_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [7:0]  cmd_core_mask;
    logic [11:0] cmd_base_addr;
    logic [11:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [11:0] gbus_addr;
    logic [7:0]  gbus_wen;
    logic [63:0] gbus_wdata;
    logic        busy;
    logic        done;
    logic        cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    gbus_wr_sched #(
        .VNUM      (8),
        .GBUS_DATA (64),
        .GBUS_ADDR (12),
        .LEN_BIT   (12)
    ) u_dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_mode_i      (cmd_mode),
        .cmd_core_mask_i (cmd_core_mask),
        .cmd_base_addr_i (cmd_base_addr),
        .cmd_len_i       (cmd_len),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_data_i       (in_data),
        .gbus_addr_o     (gbus_addr),
        .gbus_wen_o      (gbus_wen),
        .gbus_wdata_o    (gbus_wdata),
        .busy_o          (busy),
        .done_o          (done),
        .cmd_err_o       (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_wen"}, 64'(gbus_wen), 64'h0);
        check_eq({tag, "_addr"}, 64'(gbus_addr), 64'h0);
        check_eq({tag, "_wdata"}, gbus_wdata, 64'h0);
        check_eq({tag, "_done"}, 64'(done), 64'h0);
        check_eq({tag, "_err"}, 64'(cmd_err), 64'h0);
        check_eq({tag, "_busy"}, 64'(busy), 64'h0);
        check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'h1);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'h0);
    endtask

    // Runs one command; words are offered per pat (LSB first) or randomly. abort_at >= 0
    // resets the DUT right after that many words have been written.
    task automatic run_cmd(input logic mode, input logic [7:0] mask, input logic [11:0] base,
                           input logic [11:0] len, input bit use_pat, input logic [31:0] pat,
                           input int abort_at);
        int          bits[$];
        int          k;
        int          cyc;
        int          budget;
        logic        v;
        logic [63:0] d;
        logic [11:0] exp_addr;
        logic [7:0]  exp_wen;

        check_eq("pre_cmd_ready", 64'(cmd_ready), 64'h1);
        cmd_valid     = 1'b1;
        cmd_mode      = mode;
        cmd_core_mask = mask;
        cmd_base_addr = base;
        cmd_len       = len;
        in_valid      = 1'($urandom_range(0, 1));
        in_data       = {$urandom, $urandom};
        tick();
        cmd_valid = 1'b0;

        if (len == 0 || mask == 0) begin
            check_eq("degen_done", 64'(done), 64'h1);
            check_eq("degen_err", 64'(cmd_err), 64'(mask == 0));
            check_eq("degen_wen", 64'(gbus_wen), 64'h0);
            check_eq("degen_in_ready", 64'(in_ready), 64'h0);
            in_valid = 1'b1;
            tick();
            check_eq("degen_done_clr", 64'(done), 64'h0);
            check_eq("degen_err_clr", 64'(cmd_err), 64'h0);
            check_eq("degen_idle", 64'(cmd_ready), 64'h1);
            check_eq("degen_wen2", 64'(gbus_wen), 64'h0);
            check_eq("degen_in_ready2", 64'(in_ready), 64'h0);
            in_valid = 1'b0;
            return;
        end

        for (int i = 0; i < 8; i++) if (mask[i]) bits.push_back(i);
        check_eq("run_first_wen", 64'(gbus_wen), 64'h0);
        k      = 0;
        cyc    = 0;
        budget = int'(len) * 40 + 40;
        while (k < int'(len) && cyc < budget) begin
            check_eq("run_in_ready", 64'(in_ready), 64'h1);
            check_eq("run_cmd_ready", 64'(cmd_ready), 64'h0);
            v = use_pat ? pat[cyc % 32] : 1'($urandom_range(0, 3) != 0);
            d = {$urandom, $urandom};
            in_valid      = v;
            in_data       = d;
            cmd_valid     = 1'($urandom_range(0, 1));
            cmd_mode      = 1'($urandom_range(0, 1));
            cmd_core_mask = 8'($urandom);
            cmd_base_addr = 12'($urandom);
            cmd_len       = 12'($urandom);
            tick();
            cyc++;
            if (v) begin
                if (mode) begin
                    exp_addr = base + 12'(k / bits.size());
                    exp_wen  = 8'(1) << bits[k % bits.size()];
                end else begin
                    exp_addr = base + 12'(k);
                    exp_wen  = mask;
                end
                check_eq("wr_wen", 64'(gbus_wen), 64'(exp_wen));
                check_eq("wr_addr", 64'(gbus_addr), 64'(exp_addr));
                check_eq("wr_data", gbus_wdata, d);
                k++;
                check_eq("wr_done", 64'(done), 64'(k == int'(len)));
                check_eq("wr_err", 64'(cmd_err), 64'h0);
                if (k == abort_at) begin
                    in_valid  = 1'b0;
                    cmd_valid = 1'b0;
                    #2;
                    rstn = 1'b0;
                    #1;
                    check_cleared("abort");
                    @(posedge clk);
                    #1;
                    check_eq("abort_no_done", 64'(done), 64'h0);
                    @(posedge clk);
                    #3;
                    rstn = 1'b1;
                    tick();
                    check_cleared("post_abort");
                    return;
                end
            end else begin
                check_eq("stall_wen", 64'(gbus_wen), 64'h0);
                check_eq("stall_done", 64'(done), 64'h0);
            end
        end
        if (k < int'(len)) begin
            check_eq("timeout_words", 64'(k), 64'(len));
            return;
        end
        check_eq("fin_in_ready", 64'(in_ready), 64'h0);
        cmd_valid = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        tick();
        check_eq("post_idle", 64'(cmd_ready), 64'h1);
        check_eq("post_done", 64'(done), 64'h0);
        check_eq("post_wen", 64'(gbus_wen), 64'h0);
        check_eq("post_busy", 64'(busy), 64'h0);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  m;
        logic [11:0] b;
        logic [11:0] l;

        rstn          = 1'b0;
        cmd_valid     = 1'b0;
        cmd_mode      = 1'b0;
        cmd_core_mask = '0;
        cmd_base_addr = '0;
        cmd_len       = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();
        check_cleared("reset");

        in_valid = 1'b1;
        in_data  = 64'hDEADBEEFDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_in_ready", 64'(in_ready), 64'h0);
            check_eq("idle_wen", 64'(gbus_wen), 64'h0);
        end
        in_valid = 1'b0;

        run_cmd(1'b0, 8'h0F, 12'h010, 12'd3, 1'b1, 32'hFFFF_FFFF, -1);
        run_cmd(1'b1, 8'hA5, 12'h100, 12'd6, 1'b1, 32'hFFFF_FFFF, -1);
        run_cmd(1'b0, 8'h01, 12'hFFE, 12'd4, 1'b1, 32'h0000_002D, -1);
        run_cmd(1'b1, 8'h01, 12'hFFD, 12'd5, 1'b1, 32'hFFFF_FFFF, -1);
        run_cmd(1'b1, 8'h80, 12'h200, 12'd0, 1'b1, 32'hFFFF_FFFF, -1);
        run_cmd(1'b0, 8'hFF, 12'h123, 12'd0, 1'b1, 32'hFFFF_FFFF, -1);
        run_cmd(1'b1, 8'h00, 12'h123, 12'd5, 1'b1, 32'hFFFF_FFFF, -1);
        run_cmd(1'b1, 8'h5A, 12'h300, 12'd8, 1'b1, 32'hFFFF_FFFF, 3);
        run_cmd(1'b1, 8'hC3, 12'h040, 12'd7, 1'b1, 32'hFFFF_FFFF, -1);

        for (int t = 0; t < 40; t++) begin
            m = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            l = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 16));
            b = ($urandom_range(0, 1) == 1) ? 12'hFF0 + 12'($urandom_range(0, 15))
                                            : 12'($urandom);
            run_cmd(1'($urandom_range(0, 1)), m, b, l, 1'b0, 32'h0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
